// File: rtl/mul_tile_scheduler.sv
// Sequential WIDTH x WIDTH multiplier time-sharing one external TILE x TILE core.
// Accumulates shifted tile products and counts tiles where the core is inexact.
module mul_tile_scheduler #(
  parameter int WIDTH = 8,
  parameter int TILE  = 2,
  localparam int N    = WIDTH / TILE,
  localparam int T    = N * N,
  localparam int ERRW = $clog2(T + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [TILE-1:0]      core_a,
  output logic [TILE-1:0]      core_b,
  input  logic [2*TILE-1:0]    core_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [ERRW-1:0]      err_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2 * WIDTH) + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [IW-1:0]      i_cnt;
  logic [IW-1:0]      j_cnt;
  logic [2*WIDTH-1:0] acc;
  logic [ERRW-1:0]    err;
  logic               last;
  logic [2*TILE-1:0]  exact;
  logic [SW-1:0]      shamt;
  logic [2*WIDTH-1:0] addend;

  assign last = (i_cnt == IW'(N - 1)) && (j_cnt == IW'(N - 1));

  // Present the current digit pair to the core only while running
  always_comb begin
    core_a = '0;
    core_b = '0;
    if (state == RUN) begin
      core_a = a_reg[TILE*i_cnt +: TILE];
      core_b = b_reg[TILE*j_cnt +: TILE];
    end
  end

  // Reference tile product and the weighted core result
  always_comb begin
    exact  = (2*TILE)'(core_a) * (2*TILE)'(core_b);
    shamt  = SW'(TILE) * (SW'(i_cnt) + SW'(j_cnt));
    addend = (2*WIDTH)'(core_p) << shamt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, tile walk, accumulate and error count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      acc   <= '0;
      err   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            i_cnt <= '0;
            j_cnt <= '0;
            acc   <= '0;
            err   <= '0;
          end
        end
        RUN: begin
          acc <= acc + addend;
          if (core_p != exact) err <= err + 1'b1;
          if (last) begin
            i_cnt <= '0;
            j_cnt <= '0;
          end else if (i_cnt == IW'(N - 1)) begin
            i_cnt <= '0;
            j_cnt <= j_cnt + 1'b1;
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign p       = acc;
  assign err_cnt = err;

endmodule

// File: tb/tb_mul_tile_scheduler.sv
// Directed bench for mul_tile_scheduler with exact and faulty 2-bit cores.
// Each scenario task drives stimulus and checks its own results inline.
module tb_mul_tile_scheduler;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  a = 0;
  logic [7:0]  b = 0;
  logic [1:0]  core_a;
  logic [1:0]  core_b;
  logic [3:0]  core_p;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] p;
  logic [4:0]  err_cnt;
  logic        fault = 0;

  int tests = 0;
  int fails = 0;

  mul_tile_scheduler #(.WIDTH(8), .TILE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .core_a(core_a), .core_b(core_b), .core_p(core_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Candidate core model: exact, or 3*3 -> 7 when faulty
  always_comb begin
    core_p = 4'(core_a) * 4'(core_b);
    if (fault && core_a == 2'd3 && core_b == 2'd3) core_p = 4'd7;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run one operation; lat = cycles from accept edge to out_valid, -1 on timeout
  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb,
                       output logic [15:0] pr, output logic [4:0] er,
                       output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    a = xa; b = xb; in_valid = 1;
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    lat = out_valid ? n : -1;
    pr = p; er = err_cnt;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (p !== 16'h0) begin fails++; $display("FAIL reset_p got %h want 0000", p); end
    tests++; if (err_cnt !== 5'd0) begin fails++; $display("FAIL reset_err got %0d want 0", err_cnt); end
    tests++; if ({core_a, core_b} !== 4'h0) begin fails++; $display("FAIL reset_core got %h want 0", {core_a, core_b}); end
  endtask

  task automatic test_exact_ff;
    logic [15:0] pr; logic [4:0] er; int lat;
    do_op(8'hFF, 8'hFF, pr, er, lat);
    tests++; if (pr !== 16'hFE01) begin fails++; $display("FAIL ff_p got %h want fe01", pr); end
    tests++; if (er !== 5'd0) begin fails++; $display("FAIL ff_err got %0d want 0", er); end
    tests++; if (lat !== 16) begin fails++; $display("FAIL ff_latency got %0d want 16", lat); end
  endtask

  // Distinct digits: a=0xE4 digits (0,1,2,3), b=0x1B digits (3,2,1,0)
  task automatic test_sequence;
    logic [1:0] da [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] db [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    int bad;
    bad = 0;
    a = 8'hE4; b = 8'h1B; in_valid = 1;
    tick();
    in_valid = 0;
    for (int k = 0; k < 16; k++) begin
      if (core_a !== da[k % 4] || core_b !== db[k / 4] ||
          out_valid !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL seq_k%0d got a=%0d b=%0d ov=%0b ir=%0b want a=%0d b=%0d ov=0 ir=0",
                 k, core_a, core_b, out_valid, in_ready, da[k % 4], db[k / 4]);
      end
      tick();
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL seq_total got %0d bad want 0", bad); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL seq_out_valid got %0b want 1", out_valid); end
    tests++; if (p !== 16'h180C) begin fails++; $display("FAIL seq_p got %h want 180c", p); end
    tests++; if ({core_a, core_b} !== 4'h0) begin fails++; $display("FAIL seq_core_done got %h want 0", {core_a, core_b}); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_zero_and_msb;
    logic [15:0] pr; logic [4:0] er; int lat;
    do_op(8'h00, 8'hA7, pr, er, lat);
    tests++; if (pr !== 16'h0000) begin fails++; $display("FAIL zero_p got %h want 0000", pr); end
    tests++; if (er !== 5'd0) begin fails++; $display("FAIL zero_err got %0d want 0", er); end
    do_op(8'h80, 8'h02, pr, er, lat);
    tests++; if (pr !== 16'h0100) begin fails++; $display("FAIL msb_p got %h want 0100", pr); end
    tests++; if (er !== 5'd0) begin fails++; $display("FAIL msb_err got %0d want 0", er); end
  endtask

  task automatic test_faulty;
    logic [15:0] pr; logic [4:0] er; int lat;
    fault = 1;
    do_op(8'h03, 8'h03, pr, er, lat);
    tests++; if (pr !== 16'h0007) begin fails++; $display("FAIL f33_p got %h want 0007", pr); end
    tests++; if (er !== 5'd1) begin fails++; $display("FAIL f33_err got %0d want 1", er); end
    do_op(8'hFF, 8'hFF, pr, er, lat);
    tests++; if (pr !== 16'hC58F) begin fails++; $display("FAIL fff_p got %h want c58f", pr); end
    tests++; if (er !== 5'd16) begin fails++; $display("FAIL fff_err got %0d want 16", er); end
    fault = 0;
  endtask

  task automatic test_backpressure;
    int n;
    a = 8'h12; b = 8'h34; in_valid = 1;
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_done got %0b want 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      a = 8'h55 + 8'(c); b = 8'hAA;
      tick();
      tests++;
      if (p !== 16'h03A8 || err_cnt !== 5'd0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold_c%0d got p=%h e=%0d ir=%0b ov=%0b want p=03a8 e=0 ir=0 ov=1",
                 c, p, err_cnt, in_ready, out_valid);
      end
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got ir=%0b ov=%0b want ir=1 ov=0", in_ready, out_valid); end
    tests++; if (p !== 16'h03A8) begin fails++; $display("FAIL bp_idle_p got %h want 03a8", p); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] pr; logic [4:0] er; int lat;
    a = 8'hFF; b = 8'hFF; in_valid = 1;
    tick();
    in_valid = 0;
    for (int k = 0; k < 7; k++) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rmid_hs got ir=%0b ov=%0b want ir=1 ov=0", in_ready, out_valid); end
    tests++; if (p !== 16'h0) begin fails++; $display("FAIL rmid_p got %h want 0000", p); end
    do_op(8'h12, 8'h34, pr, er, lat);
    tests++; if (pr !== 16'h03A8) begin fails++; $display("FAIL rmid_next_p got %h want 03a8", pr); end
  endtask

  task automatic test_back_to_back;
    int c, acc1, acc2, nres;
    logic [15:0] p1, p2;
    c = 0; acc1 = -1; acc2 = -1; nres = 0; p1 = 'x; p2 = 'x;
    a = 8'h12; b = 8'h34; in_valid = 1; out_ready = 1;
    while (c < 200 && (acc2 < 0 || nres < 2)) begin
      if (out_valid) begin
        if (nres == 0) p1 = p; else p2 = p;
        nres++;
      end
      if (in_ready && in_valid) begin
        if (acc1 < 0) acc1 = c;
        else acc2 = c;
      end
      tick();
      c++;
      if (acc1 >= 0 && acc2 < 0) begin a = 8'hC3; b = 8'h5A; end
      if (acc2 >= 0) in_valid = 0;
    end
    in_valid = 0; out_ready = 0;
    tests++; if (acc2 - acc1 !== 18 || acc1 < 0 || acc2 < 0) begin fails++; $display("FAIL b2b_period got %0d want 18", acc2 - acc1); end
    tests++; if (p1 !== 16'h03A8) begin fails++; $display("FAIL b2b_p1 got %h want 03a8", p1); end
    tests++; if (p2 !== 16'h448E) begin fails++; $display("FAIL b2b_p2 got %h want 448e", p2); end
  endtask

  initial begin
    test_reset();
    test_exact_ff();
    test_sequence();
    test_zero_and_msb();
    test_faulty();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
